// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: default bit period, FSM state encoding and a
// counter-width helper. The receiver imports this package too, so the state
// values must not be reordered.
package uart_tx_fifo_pkg;

  // 100 MHz / 115200 baud
  localparam int unsigned ClksPerBitDefault = 868;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  // Width of a counter that must reach n-1; never narrower than 1 bit.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte write port of the UART transmitter: valid/ready handshake.
//   in_data   byte to send
//   in_valid  in_data valid; transfer happens on a clk edge with in_valid && in_ready
//   in_ready  transmitter can accept a byte this cycle
// master: the producer (game/debug logic). slave: the transmitter.
interface uart_tx_fifo_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with a separately tracked occupancy count.
//   clk, rst     clock, asynchronous active-high reset
//   push, wdata  write request and byte; ignored while full (even if popping)
//   pop, rdata   read request; rdata shows the head entry combinationally
//   full, empty  occupancy flags derived from count
//   count        entries currently stored
module uart_byte_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       wdata,
  input  logic             pop,
  output logic [7:0]       rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage needs no reset: nothing is read before it is written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter, 8N1, LSB first, fed from a small byte FIFO so producers can
// burst without waiting a frame time.
//   clk         system clock
//   rst         asynchronous active-high reset; aborts any frame, drops queued bytes
//   in_if       byte write port (slave side of the valid/ready handshake)
//   tx          UART line, registered, idle high
//   busy        a frame is in progress or bytes are queued
//   fifo_count  bytes queued, excluding the one being shifted out
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_fifo_if.slave     in_if,
  output logic              tx,
  output logic              busy,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam int unsigned ClkW = cnt_bits(CLKS_PER_BIT);

  uart_state_e     state_q, state_d;
  logic [ClkW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic            fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic            bit_end;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_if.in_valid),
    .wdata (in_if.in_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign in_if.in_ready = !fifo_full;
  assign bit_end        = (clk_cnt_q == ClkW'(CLKS_PER_BIT - 1));
  assign tx             = tx_q;
  assign busy           = (state_q != StIdle) || !fifo_empty;

  // tx_d follows the current state, so the line lags the FSM by one edge;
  // every bit still lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    tx_d      = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_rdata;
          clk_cnt_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          clk_cnt_d = clk_cnt_q + ClkW'(1);
        end
      end
      StData: begin
        tx_d = shift_q[bit_idx_q];
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) state_d = StStop;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + ClkW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = StStart;
          end else begin
            state_d  = StIdle;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + ClkW'(1);
        end
      end
      default: begin
        state_d   = StIdle;
        clk_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a fast instance (16 clocks/bit) for most
// scenarios and a 115200-baud instance (868 clocks/bit) decoded by a behavioural
// receiver for the loopback run.
module tb_uart_tx_fifo;

  localparam int unsigned FastCpb = 16;
  localparam int unsigned SlowCpb = 868;

  typedef struct {
    logic [7:0] data;
    int         t;
    bit         ok;
  } rx_rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_f, busy_f, tx_s, busy_s;
  logic [3:0] cnt_f, cnt_s;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  rx_rec_t    fq[$];
  rx_rec_t    sq[$];

  uart_tx_fifo_if in_f ();
  uart_tx_fifo_if in_s ();

  uart_tx_fifo #(
    .CLKS_PER_BIT (FastCpb),
    .FIFO_DEPTH   (8),
    .CNT_W        (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (in_f),
    .tx         (tx_f),
    .busy       (busy_f),
    .fifo_count (cnt_f)
  );

  uart_tx_fifo #(
    .CLKS_PER_BIT (SlowCpb),
    .FIFO_DEPTH   (8),
    .CNT_W        (4)
  ) dut_slow (
    .clk        (clk),
    .rst        (rst),
    .in_if      (in_s),
    .tx         (tx_s),
    .busy       (busy_s),
    .fifo_count (cnt_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  // Behavioural receiver: finds a start bit, samples mid-bit, logs each frame
  // with the cycle its start bit first appeared. Frames cut by reset are dropped.
  task automatic monitor(input bit slow);
    int         cpb;
    logic       line;
    logic [7:0] d;
    bit         ok, abort;
    int         t;
    rx_rec_t    r;
    cpb = slow ? SlowCpb : FastCpb;
    forever begin
      @(negedge clk);
      line = slow ? tx_s : tx_f;
      if (!rst && line === 1'b0) begin
        t = cyc; ok = 1'b1; abort = 1'b0; d = '0;
        for (int b = 0; b < 10; b++) begin
          repeat ((b == 0) ? cpb / 2 : cpb) begin
            @(negedge clk);
            if (rst) abort = 1'b1;
          end
          line = slow ? tx_s : tx_f;
          if (b == 0) begin
            if (line !== 1'b0) ok = 1'b0;
          end else if (b == 9) begin
            if (line !== 1'b1) ok = 1'b0;
          end else begin
            d[b-1] = line;
          end
        end
        if (!abort) begin
          r.data = d; r.t = t; r.ok = ok;
          if (slow) sq.push_back(r);
          else      fq.push_back(r);
        end
      end
    end
  endtask

  initial monitor(1'b0);
  initial monitor(1'b1);

  // Offer one byte; returns how many cycles it waited for in_ready (-1 on timeout).
  task automatic push_byte(input bit slow, input logic [7:0] b, output int waited);
    waited = 0;
    if (slow) begin in_s.in_data = b; in_s.in_valid = 1'b1; end
    else      begin in_f.in_data = b; in_f.in_valid = 1'b1; end
    while (((slow ? in_s.in_ready : in_f.in_ready) !== 1'b1) && waited >= 0) begin
      tick();
      waited++;
      if (waited > 5000) waited = -1;
    end
    tick();
    if (slow) in_s.in_valid = 1'b0;
    else      in_f.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit slow, input int limit, output bit done);
    int n = 0;
    while (((slow ? busy_s : busy_f) !== 1'b0) && n < limit) begin
      tick();
      n++;
    end
    done = ((slow ? busy_s : busy_f) === 1'b0);
  endtask

  task automatic test_reset();
    int lows = 0;
    rst = 1'b1;
    repeat (3) tick();
    n_checks += 4;
    if (tx_f !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx_f); end
    if (busy_f !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_f); end
    if (in_f.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", in_f.in_ready);
    end
    if (cnt_f !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt_f); end
    rst = 1'b0;
    repeat (100) begin
      tick();
      if (tx_f !== 1'b1 || tx_s !== 1'b1) lows++;
    end
    n_checks += 2;
    if (lows != 0) begin n_fail++; $display("FAIL idle_line: got %0d low cycles want 0", lows); end
    if (busy_f !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy_f); end
  endtask

  task automatic test_single();
    int w, n;
    fq.delete();
    push_byte(1'b0, 8'h55, w);
    n = cyc;
    n_checks += 3;
    if (cnt_f !== 4'd1) begin n_fail++; $display("FAIL single_count_n: got %0d want 1", cnt_f); end
    if (busy_f !== 1'b1) begin n_fail++; $display("FAIL single_busy_n: got %b want 1", busy_f); end
    if (tx_f !== 1'b1) begin n_fail++; $display("FAIL single_tx_n: got %b want 1", tx_f); end
    tick();
    n_checks += 2;
    if (tx_f !== 1'b1) begin n_fail++; $display("FAIL single_tx_n1: got %b want 1", tx_f); end
    if (cnt_f !== 4'd0) begin n_fail++; $display("FAIL single_count_n1: got %0d want 0", cnt_f); end
    tick();
    n_checks++;
    if (tx_f !== 1'b0) begin n_fail++; $display("FAIL single_tx_n2: got %b want 0", tx_f); end
    repeat (158) tick();
    n_checks++;
    if (busy_f !== 1'b1) begin n_fail++; $display("FAIL single_busy_n160: got %b want 1", busy_f); end
    tick();
    n_checks++;
    if (busy_f !== 1'b0) begin n_fail++; $display("FAIL single_busy_n161: got %b want 0", busy_f); end
    repeat (4) tick();
    n_checks++;
    if (fq.size() != 1) begin
      n_fail++; $display("FAIL single_frames: got %0d want 1", fq.size());
    end else begin
      n_checks += 2;
      if (fq[0].data !== 8'h55 || !fq[0].ok) begin
        n_fail++; $display("FAIL single_data: got %h ok=%b want 55 ok=1", fq[0].data, fq[0].ok);
      end
      if (fq[0].t != n + 2) begin
        n_fail++; $display("FAIL single_start: got cycle %0d want %0d", fq[0].t, n + 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w, n;
    bit done;
    fq.delete();
    for (int k = 0; k < 4; k++) begin
      push_byte(1'b0, 8'(k + 1), w);
      if (k == 0) n = cyc;
    end
    wait_idle(1'b0, 2000, done);
    repeat (4) tick();
    n_checks += 2;
    if (!done) begin n_fail++; $display("FAIL b2b_idle: got busy want idle"); end
    if (fq.size() != 4) begin
      n_fail++; $display("FAIL b2b_frames: got %0d want 4", fq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks += 2;
        if (fq[k].data !== 8'(k + 1) || !fq[k].ok) begin
          n_fail++;
          $display("FAIL b2b_data%0d: got %h ok=%b want %h", k, fq[k].data, fq[k].ok, k + 1);
        end
        if (fq[k].t != n + 2 + 160 * k) begin
          n_fail++;
          $display("FAIL b2b_start%0d: got cycle %0d want %0d", k, fq[k].t, n + 2 + 160 * k);
        end
      end
    end
  endtask

  // Nine bytes go in without stalling (one is popped right away), leaving 8
  // queued; the tenth waits until the first frame ends and frees a slot.
  task automatic test_fifo_full();
    int w, n, total;
    bit done;
    fq.delete();
    total = 0;
    for (int k = 0; k < 9; k++) begin
      push_byte(1'b0, 8'(8'h10 + k), w);
      if (k == 0) n = cyc;
      total += w;
    end
    n_checks += 3;
    if (total != 0) begin n_fail++; $display("FAIL full_stall9: got %0d want 0", total); end
    if (cnt_f !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d want 8", cnt_f); end
    if (in_f.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_ready: got %b want 0", in_f.in_ready);
    end
    push_byte(1'b0, 8'h19, w);
    n_checks += 2;
    if (w != 153) begin n_fail++; $display("FAIL full_stall10: got %0d want 153", w); end
    if (cnt_f !== 4'd8) begin n_fail++; $display("FAIL full_count10: got %0d want 8", cnt_f); end
    wait_idle(1'b0, 3000, done);
    repeat (4) tick();
    n_checks += 2;
    if (!done) begin n_fail++; $display("FAIL full_idle: got busy want idle"); end
    if (fq.size() != 10) begin
      n_fail++; $display("FAIL full_frames: got %0d want 10", fq.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        n_checks++;
        if (fq[k].data !== 8'(8'h10 + k) || !fq[k].ok || fq[k].t != n + 2 + 160 * k) begin
          n_fail++;
          $display("FAIL full_frame%0d: got %h ok=%b t=%0d want %h t=%0d", k, fq[k].data,
                   fq[k].ok, fq[k].t, 8'h10 + k, n + 2 + 160 * k);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int w, lows;
    bit done;
    fq.delete();
    push_byte(1'b0, 8'hA5, w);
    push_byte(1'b0, 8'h11, w);
    push_byte(1'b0, 8'h22, w);
    push_byte(1'b0, 8'h33, w);
    n_checks++;
    if (cnt_f !== 4'd3) begin n_fail++; $display("FAIL rstmid_count: got %0d want 3", cnt_f); end
    // Now at N+3; N+70 is the middle of data bit 3 of 0xA5, which is 0.
    repeat (67) tick();
    n_checks++;
    if (tx_f !== 1'b0) begin n_fail++; $display("FAIL rstmid_bit3: got %b want 0", tx_f); end
    #2 rst = 1'b1;
    #1;
    n_checks += 4;
    if (tx_f !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b want 1", tx_f); end
    if (cnt_f !== 4'd0) begin n_fail++; $display("FAIL rstmid_count0: got %0d want 0", cnt_f); end
    if (busy_f !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy_f); end
    if (in_f.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_ready: got %b want 1", in_f.in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lows = 0;
    repeat (400) begin
      tick();
      if (tx_f !== 1'b1) lows++;
    end
    wait_idle(1'b0, 10, done);
    n_checks += 3;
    if (lows != 0) begin n_fail++; $display("FAIL rstmid_line: got %0d low cycles want 0", lows); end
    if (fq.size() != 0) begin n_fail++; $display("FAIL rstmid_frames: got %0d want 0", fq.size()); end
    if (!done) begin n_fail++; $display("FAIL rstmid_idle: got busy want idle"); end
  endtask

  task automatic test_loopback_slow();
    int w, n;
    bit done;
    sq.delete();
    push_byte(1'b1, 8'hA5, w);
    n = cyc;
    push_byte(1'b1, 8'h3C, w);
    wait_idle(1'b1, 20000, done);
    repeat (4) tick();
    n_checks += 2;
    if (!done) begin n_fail++; $display("FAIL loop_idle: got busy want idle"); end
    if (sq.size() != 2) begin
      n_fail++; $display("FAIL loop_frames: got %0d want 2", sq.size());
    end else begin
      n_checks += 3;
      if (sq[0].data !== 8'hA5 || !sq[0].ok) begin
        n_fail++; $display("FAIL loop_data0: got %h ok=%b want a5", sq[0].data, sq[0].ok);
      end
      if (sq[1].data !== 8'h3C || !sq[1].ok) begin
        n_fail++; $display("FAIL loop_data1: got %h ok=%b want 3c", sq[1].data, sq[1].ok);
      end
      if (sq[0].t != n + 2 || sq[1].t != n + 2 + 10 * SlowCpb) begin
        n_fail++;
        $display("FAIL loop_timing: got %0d,%0d want %0d,%0d", sq[0].t, sq[1].t, n + 2,
                 n + 2 + 10 * SlowCpb);
      end
    end
  endtask

  initial begin
    in_f.in_data = '0; in_f.in_valid = 1'b0;
    in_s.in_data = '0; in_s.in_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_frame();
    test_loopback_slow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
